// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM port arbiter for IF fetches and MEM loads/stores
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_cancel,
    output logic        if_busy,
    output logic        if_done,
    output logic [31:0] if_inst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_wdata,
    output logic        mem_busy,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IF_RD  = 2'd1,
        S_MEM_RD = 2'd2,
        S_MEM_WR = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] base_q, base_d;
    logic [2:0]  size_q, size_d;
    logic [23:0] buf_q, buf_d;
    logic [31:0] wdata_q, wdata_d;

    logic [2:0]  mem_n;
    logic [31:0] rd_word;
    logic        rd_last;

    assign if_busy  = if_req & ~if_done;
    assign mem_busy = mem_req & ~mem_done;
    assign rd_last  = (cnt_q == size_q);

    // Decode the MEM access size into a byte count (11 is treated as a word)
    always_comb begin
        case (mem_size)
            2'b00:   mem_n = 3'd1;
            2'b01:   mem_n = 3'd2;
            default: mem_n = 3'd4;
        endcase
    end

    // Final read word: buffered low bytes plus the byte arriving this cycle on top
    always_comb begin
        case (size_q)
            3'd1:    rd_word = {24'd0, ram_din};
            3'd2:    rd_word = {16'd0, ram_din, buf_q[7:0]};
            default: rd_word = {ram_din, buf_q};
        endcase
    end

    // State and datapath registers; reset clears everything so no done can follow
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            base_q  <= 32'd0;
            size_q  <= 3'd0;
            buf_q   <= 24'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            size_q  <= size_d;
            buf_q   <= buf_d;
            wdata_q <= wdata_d;
        end
    end

    // Arbitration, byte sequencing and RAM port drive
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        size_d    = size_q;
        buf_d     = buf_q;
        wdata_d   = wdata_q;
        ram_a     = 32'd0;
        ram_dout  = 8'd0;
        ram_wr    = 1'b0;
        if_done   = 1'b0;
        if_inst   = 32'd0;
        mem_done  = 1'b0;
        mem_rdata = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    state_d = mem_we ? S_MEM_WR : S_MEM_RD;
                    cnt_d   = 3'd0;
                    base_d  = mem_addr;
                    size_d  = mem_n;
                    wdata_d = mem_wdata;
                    buf_d   = 24'd0;
                end else if (if_req && !if_cancel) begin
                    state_d = S_IF_RD;
                    cnt_d   = 3'd0;
                    base_d  = if_addr;
                    size_d  = 3'd4;
                    wdata_d = 32'd0;
                    buf_d   = 24'd0;
                end
            end

            S_IF_RD, S_MEM_RD: begin
                if (cnt_q < size_q) begin
                    ram_a = base_q + {29'd0, cnt_q};
                end
                // ram_din carries the byte addressed in the previous cycle
                if (cnt_q != 3'd0 && cnt_q < size_q) begin
                    case (cnt_q)
                        3'd1:    buf_d[7:0]   = ram_din;
                        3'd2:    buf_d[15:8]  = ram_din;
                        3'd3:    buf_d[23:16] = ram_din;
                        default: buf_d        = buf_q;
                    endcase
                end
                if (state_q == S_IF_RD && if_cancel) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end else if (rd_last) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                    if (state_q == S_IF_RD) begin
                        if_done = 1'b1;
                        if_inst = rd_word;
                    end else begin
                        mem_done  = 1'b1;
                        mem_rdata = rd_word;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            S_MEM_WR: begin
                ram_a  = base_q + {29'd0, cnt_q};
                ram_wr = 1'b1;
                case (cnt_q[1:0])
                    2'd0:    ram_dout = wdata_q[7:0];
                    2'd1:    ram_dout = wdata_q[15:8];
                    2'd2:    ram_dout = wdata_q[23:16];
                    default: ram_dout = wdata_q[31:24];
                endcase
                if (cnt_q == size_q - 3'd1) begin
                    state_d  = S_IDLE;
                    cnt_d    = 3'd0;
                    mem_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_cancel;
    logic        if_busy;
    logic        if_done;
    logic [31:0] if_inst;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic [31:0] mem_wdata;
    logic        mem_busy;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_din = 8'h00;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    typedef struct {
        bit          is_if;
        bit          we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_cancel (if_cancel),
        .if_busy   (if_busy),
        .if_done   (if_done),
        .if_inst   (if_inst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_size  (mem_size),
        .mem_wdata (mem_wdata),
        .mem_busy  (mem_busy),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ram_a     (ram_a),
        .ram_wr    (ram_wr)
    );

    // Synchronous byte RAM: read data appears one cycle after the address
    always @(posedge clk) begin
        logic [7:0] rd;
        rd = ram_mem.exists(ram_a) ? ram_mem[ram_a] : 8'h00;
        if (ram_wr) ram_mem[ram_a] = ram_dout;
        ram_din <= rd;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] v);
        ram_mem[a] = v;
        ref_mem[a] = v;
    endtask

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < n; k++) w[8*k +: 8] = ref_rd(a + 32'(k));
        return w;
    endfunction

    function automatic int nbytes(input bit is_if, input logic [1:0] size);
        if (is_if) return 4;
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    // One complete transaction from an IDLE cycle; checks the RAM port every cycle
    task automatic txn(input bit is_if, input bit we, input logic [31:0] addr,
                       input logic [1:0] size, input logic [31:0] wdata, input bit noise,
                       output logic [31:0] got, output int lat);
        int   n;
        bit   st;
        bit   fin;
        logic d;
        logic b;
        n   = nbytes(is_if, size);
        st  = we && !is_if;
        got = 32'd0;
        lat = -1;
        fin = 1'b0;
        if (is_if) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            mem_req   = 1'b1;
            mem_we    = we;
            mem_addr  = addr;
            mem_size  = size;
            mem_wdata = wdata;
        end
        for (int c = 0; c < 12 && !fin; c++) begin
            if (noise && !is_if) if_cancel = 1'($urandom_range(0, 1));
            @(negedge clk);
            d = is_if ? if_done : mem_done;
            b = is_if ? if_busy : mem_busy;
            check1($sformatf("txn c%0d busy", c), b, !d);
            if (c >= 1 && c <= n) begin
                check($sformatf("txn c%0d ram_a", c), ram_a, addr + 32'(c - 1));
                check1($sformatf("txn c%0d ram_wr", c), ram_wr, st);
                if (st) check($sformatf("txn c%0d ram_dout", c), {24'd0, ram_dout},
                              {24'd0, wdata[8*(c-1) +: 8]});
            end else begin
                check($sformatf("txn c%0d idle ram_a", c), ram_a, 32'd0);
                check1($sformatf("txn c%0d idle ram_wr", c), ram_wr, 1'b0);
            end
            if (d) begin
                fin = 1'b1;
                lat = c;
                got = is_if ? if_inst : mem_rdata;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!fin) check1("txn timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        if_req    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        if_cancel = 1'b0;
        if (st && fin) begin
            for (int k = 0; k < n; k++) ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        int          lat;

        rst       = 1'b0;
        if_req    = 1'b1;
        if_addr   = 32'h100;
        if_cancel = 1'b0;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h40;
        mem_size  = 2'b10;
        mem_wdata = 32'h12345678;

        poke(32'h100, 8'h13);
        poke(32'h101, 8'h05);
        poke(32'h102, 8'h10);
        poke(32'h103, 8'h00);
        poke(32'h20, 8'hF0);
        poke(32'h21, 8'h80);

        // Reset holds the controller idle even with both requests raised
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check1("rst ram_wr", ram_wr, 1'b0);
            check("rst ram_a", ram_a, 32'd0);
            check("rst ram_dout", {24'd0, ram_dout}, 32'd0);
            check1("rst if_done", if_done, 1'b0);
            check1("rst mem_done", mem_done, 1'b0);
            check("rst if_inst", if_inst, 32'd0);
            check("rst mem_rdata", mem_rdata, 32'd0);
            @(posedge clk);
            #1;
        end
        if_req  = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;

        vecs[0] = '{1'b1, 1'b0, 32'h00000100, 2'b10, 32'h0,        32'h00100513, 5};
        vecs[1] = '{1'b0, 1'b0, 32'h00000020, 2'b00, 32'h0,        32'h000000F0, 2};
        vecs[2] = '{1'b0, 1'b0, 32'h00000020, 2'b01, 32'h0,        32'h000080F0, 3};
        vecs[3] = '{1'b0, 1'b1, 32'h00000040, 2'b10, 32'hDEADBEEF, 32'h0,        4};
        vecs[4] = '{1'b0, 1'b0, 32'h00000040, 2'b10, 32'h0,        32'hDEADBEEF, 5};
        vecs[5] = '{1'b0, 1'b1, 32'hFFFFFFFF, 2'b01, 32'h00001234, 32'h0,        2};
        vecs[6] = '{1'b0, 1'b0, 32'hFFFFFFFE, 2'b10, 32'h0,        32'h00123400, 5};
        vecs[7] = '{1'b0, 1'b0, 32'h00000100, 2'b11, 32'h0,        32'h00100513, 5};
        vecs[8] = '{1'b0, 1'b1, 32'h00000022, 2'b00, 32'h000000AA, 32'h0,        1};
        vecs[9] = '{1'b0, 1'b0, 32'h00000020, 2'b10, 32'h0,        32'h00AA80F0, 5};

        for (int i = 0; i < 10; i++) begin
            txn(vecs[i].is_if, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata,
                1'b0, got, lat);
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
            if (vecs[i].is_if || !vecs[i].we)
                check($sformatf("vec%0d data", i), got, vecs[i].exp_data);
        end

        // Simultaneous requests: MEM first, one IDLE cycle, then the fetch
        if_req   = 1'b1;
        if_addr  = 32'h100;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h40;
        mem_size = 2'b10;
        for (int c = 0; c < 12; c++) begin
            if (c == 6) mem_req = 1'b0;
            @(negedge clk);
            check1($sformatf("sim c%0d mem_done", c), mem_done, c == 5);
            check1($sformatf("sim c%0d if_done", c), if_done, c == 11);
            check1($sformatf("sim c%0d if_busy", c), if_busy, c <= 10);
            check1($sformatf("sim c%0d mem_busy", c), mem_busy, c <= 4);
            if (c == 5) check("sim mem_rdata", mem_rdata, 32'hDEADBEEF);
            if (c == 11) check("sim if_inst", if_inst, 32'h00100513);
            if (c == 6) check("sim gap ram_a", ram_a, 32'd0);
            if (c == 7) check("sim fetch ram_a", ram_a, 32'h100);
            @(posedge clk);
            #1;
        end
        if_req = 1'b0;

        // Cancel mid-fetch and in the done cycle; the held request refetches
        for (int k = 0; k < 2; k++) begin
            int cc;
            cc      = (k == 0) ? 2 : 5;
            if_req  = 1'b1;
            if_addr = 32'h100;
            for (int c = 0; c <= cc + 6; c++) begin
                if (c == cc) if_cancel = 1'b1;
                if (c == cc + 1) begin
                    if_cancel = 1'b0;
                    if_addr   = 32'h40;
                end
                @(negedge clk);
                check1($sformatf("cancel%0d c%0d if_done", cc, c), if_done, c == cc + 6);
                check1($sformatf("cancel%0d c%0d if_busy", cc, c), if_busy, c <= cc + 5);
                if (c == cc + 1) check($sformatf("cancel%0d idle ram_a", cc), ram_a, 32'd0);
                if (c == cc + 2) check($sformatf("cancel%0d new ram_a", cc), ram_a, 32'h40);
                if (c == cc + 6) check($sformatf("cancel%0d if_inst", cc), if_inst, 32'hDEADBEEF);
                @(posedge clk);
                #1;
            end
            if_req = 1'b0;
        end

        // Reset in cycle 2 of a word store
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h300;
        mem_size  = 2'b10;
        mem_wdata = 32'h11223344;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) rst = 1'b0;
            @(negedge clk);
            if (c == 1 || c == 2) check1($sformatf("rstmid c%0d ram_wr", c), ram_wr, 1'b1);
            if (c == 1) check("rstmid c1 ram_dout", {24'd0, ram_dout}, 32'h44);
            if (c >= 3) begin
                check1($sformatf("rstmid c%0d ram_wr", c), ram_wr, 1'b0);
                check($sformatf("rstmid c%0d ram_a", c), ram_a, 32'd0);
                check($sformatf("rstmid c%0d ram_dout", c), {24'd0, ram_dout}, 32'd0);
                check1($sformatf("rstmid c%0d mem_done", c), mem_done, 1'b0);
            end
            @(posedge clk);
            #1;
        end
        rst     = 1'b1;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        txn(1'b0, 1'b1, 32'h300, 2'b10, 32'hCAFEF00D, 1'b0, got, lat);
        check("rstmid restore latency", lat, 4);
        txn(1'b0, 1'b0, 32'h300, 2'b10, 32'h0, 1'b0, got, lat);
        check("rstmid readback", got, 32'hCAFEF00D);

        // Random traffic against the byte-array reference model
        for (int i = 0; i < 40; i++) begin
            bit          r_if;
            bit          r_we;
            logic [1:0]  r_size;
            logic [31:0] r_addr;
            logic [31:0] r_wdata;
            logic [31:0] exp;
            int          n;
            r_if    = ($urandom_range(0, 3) == 0);
            r_we    = 1'($urandom_range(0, 1));
            r_size  = 2'($urandom_range(0, 3));
            r_addr  = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                                   : 32'h400 + 32'($urandom_range(0, 15));
            r_wdata = $urandom;
            n       = nbytes(r_if, r_size);
            exp     = ref_word(r_addr, n);
            txn(r_if, r_we, r_addr, r_size, r_wdata, 1'b1, got, lat);
            if (r_we && !r_if) begin
                check($sformatf("rand%0d store latency", i), lat, n);
            end else begin
                check($sformatf("rand%0d load latency", i), lat, n + 1);
                check($sformatf("rand%0d load data", i), got, exp);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
